// File: rtl/tile_sb_sequencer.sv
// rtl/tile_sb_sequencer.sv - raster superblock sequencer with stage handshakes, watchdog and write bursts
module tile_sb_sequencer #(
    parameter int SB_LOG2 = 6,
    parameter int DIM_W   = 16,
    parameter int BURST   = 16,
    parameter int TO_W    = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DIM_W-1:0]     frame_width,
    input  logic [DIM_W-1:0]     frame_height,
    output logic [2:0]           stage_req,
    input  logic [2:0]           stage_done,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [2*DIM_W-1:0]   wr_addr,
    output logic [7:0]           wr_len,
    output logic [DIM_W-1:0]     sb_row,
    output logic [DIM_W-1:0]     sb_col,
    output logic [2*DIM_W-1:0]   sb_count,
    output logic [3:0]           state,
    output logic                 busy,
    output logic                 tile_done,
    output logic                 error,
    output logic [1:0]           err_stage
);

    localparam int AW = 2 * DIM_W;
    localparam logic [DIM_W:0]   SB_RND  = (DIM_W+1)'((1 << SB_LOG2) - 1);
    localparam logic [DIM_W:0]   ONE_EXT = (DIM_W+1)'(1);
    localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT);
    localparam logic [AW-1:0]    BURST_W = AW'(BURST);
    localparam logic [7:0]       BURST_B = 8'(BURST);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SB_HDR  = 4'd1,
        S_ENT     = 4'd2,
        S_ITX     = 4'd3,
        S_PRED    = 4'd4,
        S_RECON   = 4'd5,
        S_WRITE   = 4'd6,
        S_DONE    = 4'd7,
        S_NEXT_SB = 4'd8,
        S_ERROR   = 4'd9
    } state_t;

    state_t             state_q, state_n;
    logic [DIM_W:0]     sb_cols_q, sb_cols_n, sb_rows_q, sb_rows_n;
    logic [AW-1:0]      total_q, total_n;
    logic [DIM_W-1:0]   sb_row_q, sb_row_n, sb_col_q, sb_col_n;
    logic [AW-1:0]      sb_count_q, sb_count_n;
    logic [AW-1:0]      off_q, off_n;
    logic [7:0]         len_q, len_n;
    logic [TO_W-1:0]    wd_q, wd_n;
    logic               error_q, error_n;
    logic [1:0]         err_stage_q, err_stage_n;
    logic [2:0]         stage_req_q, stage_req_n;
    logic               wr_valid_q, wr_valid_n;
    logic               tile_done_q, tile_done_n;
    logic               busy_q, busy_n;

    logic [1:0]         sidx;
    state_t             snext;
    logic [AW-1:0]      off_sum;

    function automatic logic [7:0] beat_len(input logic [AW-1:0] rem);
        if (rem > BURST_W)
            return BURST_B;
        else
            return rem[7:0];
    endfunction

    always_comb begin
        state_n     = state_q;
        sb_cols_n   = sb_cols_q;
        sb_rows_n   = sb_rows_q;
        total_n     = total_q;
        sb_row_n    = sb_row_q;
        sb_col_n    = sb_col_q;
        sb_count_n  = sb_count_q;
        off_n       = off_q;
        len_n       = len_q;
        wd_n        = wd_q;
        error_n     = error_q;
        err_stage_n = err_stage_q;
        sidx        = 2'd0;
        snext       = S_ITX;
        off_sum     = off_q + AW'(len_q);

        if (abort) begin
            state_n     = S_IDLE;
            error_n     = 1'b0;
            err_stage_n = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // Round-up division done one bit wider so W = 2^DIM_W-1 cannot wrap.
                        sb_cols_n  = ({1'b0, frame_width} + SB_RND) >> SB_LOG2;
                        sb_rows_n  = ({1'b0, frame_height} + SB_RND) >> SB_LOG2;
                        total_n    = AW'(frame_width) * AW'(frame_height);
                        sb_row_n   = '0;
                        sb_col_n   = '0;
                        sb_count_n = '0;
                        off_n      = '0;
                        if (frame_width == '0 || frame_height == '0)
                            state_n = S_DONE;
                        else
                            state_n = S_SB_HDR;
                    end
                end
                S_SB_HDR: begin
                    wd_n    = '0;
                    state_n = S_ENT;
                end
                S_ENT, S_ITX, S_PRED: begin
                    if (state_q == S_ENT) begin
                        sidx  = 2'd0;
                        snext = S_ITX;
                    end else if (state_q == S_ITX) begin
                        sidx  = 2'd1;
                        snext = S_PRED;
                    end else begin
                        sidx  = 2'd2;
                        snext = S_RECON;
                    end
                    // A done arriving on the timeout cycle still counts as completion.
                    if (stage_done[sidx]) begin
                        wd_n    = '0;
                        state_n = snext;
                    end else if (wd_q == TO_LIM) begin
                        state_n     = S_ERROR;
                        error_n     = 1'b1;
                        err_stage_n = sidx;
                    end else begin
                        wd_n = wd_q + 1'b1;
                    end
                end
                S_RECON: state_n = S_NEXT_SB;
                S_NEXT_SB: begin
                    sb_count_n = sb_count_q + 1'b1;
                    if ({1'b0, sb_col_q} < sb_cols_q - ONE_EXT) begin
                        sb_col_n = sb_col_q + 1'b1;
                        state_n  = S_SB_HDR;
                    end else if ({1'b0, sb_row_q} < sb_rows_q - ONE_EXT) begin
                        sb_col_n = '0;
                        sb_row_n = sb_row_q + 1'b1;
                        state_n  = S_SB_HDR;
                    end else begin
                        len_n   = beat_len(total_q - off_q);
                        state_n = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        off_n = off_sum;
                        if (off_sum == total_q)
                            state_n = S_DONE;
                        else
                            len_n = beat_len(total_q - off_sum);
                    end
                end
                S_DONE:  state_n = S_IDLE;
                S_ERROR: state_n = S_ERROR;
                default: state_n = S_IDLE;
            endcase
        end

        // Handshake outputs are registered from the next state so they rise with the state.
        stage_req_n = {state_n == S_PRED, state_n == S_ITX, state_n == S_ENT};
        wr_valid_n  = (state_n == S_WRITE);
        tile_done_n = (state_n == S_DONE);
        busy_n      = (state_n != S_IDLE) && (state_n != S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sb_cols_q   <= '0;
            sb_rows_q   <= '0;
            total_q     <= '0;
            sb_row_q    <= '0;
            sb_col_q    <= '0;
            sb_count_q  <= '0;
            off_q       <= '0;
            len_q       <= '0;
            wd_q        <= '0;
            error_q     <= 1'b0;
            err_stage_q <= 2'd0;
            stage_req_q <= 3'd0;
            wr_valid_q  <= 1'b0;
            tile_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            sb_cols_q   <= sb_cols_n;
            sb_rows_q   <= sb_rows_n;
            total_q     <= total_n;
            sb_row_q    <= sb_row_n;
            sb_col_q    <= sb_col_n;
            sb_count_q  <= sb_count_n;
            off_q       <= off_n;
            len_q       <= len_n;
            wd_q        <= wd_n;
            error_q     <= error_n;
            err_stage_q <= err_stage_n;
            stage_req_q <= stage_req_n;
            wr_valid_q  <= wr_valid_n;
            tile_done_q <= tile_done_n;
            busy_q      <= busy_n;
        end
    end

    assign state     = 4'(state_q);
    assign stage_req = stage_req_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = off_q;
    assign wr_len    = len_q;
    assign sb_row    = sb_row_q;
    assign sb_col    = sb_col_q;
    assign sb_count  = sb_count_q;
    assign busy      = busy_q;
    assign tile_done = tile_done_q;
    assign error     = error_q;
    assign err_stage = err_stage_q;

endmodule

// File: tb/tb_tile_sb_sequencer.sv
// tb/tb_tile_sb_sequencer.sv - directed bench with a raster/burst scoreboard for tile_sb_sequencer
module tb_tile_sb_sequencer;

    localparam int DIM_W = 16;

    logic               clk = 1'b0;
    logic               rst, start, abort, wr_ready;
    logic [DIM_W-1:0]   frame_width, frame_height;
    logic [2:0]         stage_done, stage_req;
    logic               wr_valid, busy, tile_done, error;
    logic [2*DIM_W-1:0] wr_addr, sb_count;
    logic [7:0]         wr_len;
    logic [DIM_W-1:0]   sb_row, sb_col;
    logic [3:0]         state;
    logic [1:0]         err_stage;

    tile_sb_sequencer #(.SB_LOG2(6), .DIM_W(DIM_W), .BURST(16), .TO_W(10), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .frame_width(frame_width), .frame_height(frame_height),
        .stage_req(stage_req), .stage_done(stage_done),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_len(wr_len),
        .sb_row(sb_row), .sb_col(sb_col), .sb_count(sb_count), .state(state),
        .busy(busy), .tile_done(tile_done), .error(error), .err_stage(err_stage)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Scoreboard: raster superblock list and pixel-offset tracking
    bit     m_active = 1'b0;
    longint m_total, m_off, last_addr;
    int     q_row[$], q_col[$];
    int     m_sb_idx, m_beats, last_len;
    int     td_count = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_start(input int w, input int h);
        int cols, rows;
        m_total = longint'(w) * longint'(h);
        m_off = 0;
        q_row.delete();
        q_col.delete();
        cols = (w + 63) / 64;
        rows = (h + 63) / 64;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
                q_row.push_back(r);
                q_col.push_back(c);
            end
        m_sb_idx = 0;
        m_beats = 0;
        m_active = 1'b1;
    endtask

    initial begin : compare
        logic [3:0] prev_state;
        longint rem, len;
        int exp_req;
        prev_state = 4'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_req = (state == 4'd2) ? 1 : (state == 4'd3) ? 2 : (state == 4'd4) ? 4 : 0;
                chk("req_vs_state", stage_req, exp_req);
                chk("valid_vs_state", wr_valid, state == 4'd6);
                chk("done_vs_state", tile_done, state == 4'd7);
                chk("busy_vs_state", busy, state != 4'd0 && state != 4'd9);
                if (tile_done) td_count++;
                if (m_active && state == 4'd1 && prev_state != 4'd1) begin
                    if (m_sb_idx < q_row.size()) begin
                        chk("sb_row_order", sb_row, q_row[m_sb_idx]);
                        chk("sb_col_order", sb_col, q_col[m_sb_idx]);
                        chk("sb_count_at_hdr", sb_count, m_sb_idx);
                    end else begin
                        chk("sb_extra_visit", m_sb_idx, q_row.size() - 1);
                    end
                    m_sb_idx++;
                end
                if (m_active && state == 4'd6) begin
                    rem = m_total - m_off;
                    len = (rem > 16) ? 16 : rem;
                    chk("wr_addr", wr_addr, m_off);
                    chk("wr_len", wr_len, len);
                    if (wr_ready) begin
                        last_addr = longint'(wr_addr);
                        last_len = int'(wr_len);
                        m_off += len;
                        m_beats++;
                    end
                end
            end
            prev_state = state;
        end
    end

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input string nm, output int at);
        int n;
        n = 0;
        at = -1;
        forever begin
            at_neg();
            if (state == s) begin
                at = cyc;
                break;
            end
            n++;
            if (n > 3000) begin
                checks++;
                errors++;
                $display("FAIL %s: state %0d never reached, stuck in %0d", nm, s, state);
                break;
            end
        end
    endtask

    task automatic do_start(input int w, input int h, output int t0);
        at_pos();
        frame_width = DIM_W'(w);
        frame_height = DIM_W'(h);
        start = 1'b1;
        t0 = cyc;
        if (w != 0 && h != 0) model_start(w, h);
        at_pos();
        start = 1'b0;
        frame_width = DIM_W'($urandom);
        frame_height = DIM_W'($urandom);
    endtask

    initial begin : stim
        int t0, at, e, w, td0;
        int pat[4];
        int expa[4];
        pat = '{1, 0, 0, 1};
        expa = '{0, 16, 16, 16};
        rst = 1'b1; start = 1'b0; abort = 1'b0; wr_ready = 1'b0;
        stage_done = 3'b000; frame_width = '0; frame_height = '0;
        repeat (3) at_pos();
        rst = 1'b0;
        at_neg();
        chk("reset_state", state, 0);
        chk("reset_error", error, 0);
        chk("reset_sb_count", sb_count, 0);

        // 64x64, everything immediately done
        stage_done = 3'b111; wr_ready = 1'b1;
        td0 = td_count;
        do_start(64, 64, t0);
        wait_state(4'd2, "ent64", at);
        chk("ent_cycle", at - t0, 2);
        chk("ent_req", stage_req, 1);
        wait_state(4'd6, "write64", at);
        chk("write_entry_cycle", at - t0, 7);
        wait_state(4'd7, "done64", at);
        chk("tile_done_cycle", at - t0, 263);
        at_neg();
        chk("idle_after_done", state, 0);
        chk("tile_done_pulses", td_count - td0, 1);
        chk("beats_64", m_beats, 256);
        chk("sb_count_64", sb_count, 1);

        // 130x70: 3x2 superblocks, partial last beat
        do_start(130, 70, t0);
        wait_state(4'd7, "done130", at);
        at_neg();
        chk("sb_visits_130", m_sb_idx, 6);
        chk("sb_count_130", sb_count, 6);
        chk("beats_130", m_beats, 569);
        chk("last_addr_130", last_addr, 9088);
        chk("last_len_130", last_len, 12);

        // itx watchdog expiry, start ignored in ERROR, abort recovers
        stage_done = 3'b001;
        do_start(64, 64, t0);
        wait_state(4'd3, "itx_entry", e);
        wait_state(4'd9, "to_error", at);
        m_active = 1'b0;
        chk("timeout_latency", at - e, 16);
        chk("err_flag", error, 1);
        chk("err_stage", err_stage, 1);
        chk("err_req", stage_req, 0);
        at_pos(); start = 1'b1;
        at_pos(); start = 1'b0;
        at_neg();
        chk("error_ignores_start", state, 9);
        chk("error_sticky", error, 1);
        at_pos(); abort = 1'b1;
        at_pos(); abort = 1'b0;
        at_neg();
        chk("abort_from_error_state", state, 0);
        chk("abort_clears_error", error, 0);
        chk("abort_clears_err_stage", err_stage, 0);

        // done on the timeout cycle wins; stray pred done ignored in ENT
        stage_done = 3'b100; wr_ready = 1'b1;
        do_start(20, 10, t0);
        wait_state(4'd2, "ent_edge", e);
        repeat (15) at_pos();
        stage_done = 3'b101;
        at_neg();
        chk("ent_held_by_stray", state, 2);
        at_pos(); stage_done = 3'b111;
        at_neg();
        chk("done_beats_timeout", state, 3);
        chk("no_error_on_edge", error, 0);
        wait_state(4'd7, "done20", at);
        at_neg();
        chk("beats_20x10", m_beats, 13);
        chk("last_addr_20x10", last_addr, 192);
        chk("last_len_20x10", last_len, 8);

        // back-pressure 1,0,0,1 then abort mid-WRITE
        wr_ready = 1'b0;
        do_start(64, 64, t0);
        wait_state(4'd6, "write_bp", w);
        chk("bp_addr_first", wr_addr, 0);
        for (int i = 0; i < 4; i++) begin
            at_pos(); wr_ready = pat[i][0];
            at_neg();
            chk("bp_addr_seq", wr_addr, expa[i]);
            chk("bp_len_seq", wr_len, 16);
        end
        at_pos(); wr_ready = 1'b0;
        at_neg();
        chk("bp_addr_after", wr_addr, 32);
        at_pos(); abort = 1'b1; m_active = 1'b0; td0 = td_count;
        at_pos(); abort = 1'b0;
        at_neg();
        chk("abort_write_state", state, 0);
        chk("abort_write_valid", wr_valid, 0);
        chk("abort_sb_count_held", sb_count, 1);
        at_neg();
        at_neg();
        chk("abort_no_tile_done", td_count - td0, 0);

        // rst mid-ENT
        stage_done = 3'b000;
        do_start(64, 64, t0);
        at_neg();
        chk("count_cleared_on_start", sb_count, 0);
        wait_state(4'd2, "ent_rst", e);
        at_pos(); rst = 1'b1; m_active = 1'b0;
        at_pos(); rst = 1'b0;
        at_neg();
        chk("rst_state", state, 0);
        chk("rst_req", stage_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_outputs_or", {wr_valid, wr_addr, wr_len, sb_row, sb_col, sb_count, tile_done, error, err_stage}, 0);

        // zero-width frame
        stage_done = 3'b111;
        do_start(0, 50, t0);
        at_neg();
        chk("zero_done_state", state, 7);
        chk("zero_tile_done", tile_done, 1);
        at_neg();
        chk("zero_back_idle", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_sb_sequencer.md
# tile_sb_sequencer

Parametrised superblock sequencer for the tile decode path. It walks a frame in raster superblock order with a configurable superblock size, and drives entropy, inverse-transform and prediction sub-blocks through per-stage req/done handshakes with a watchdog timeout. After the last superblock it streams output write bursts under ready/valid back-pressure, then signals tile completion. It sits between the frame-level control and the stage engines, and replaces fixed-latency stage modelling with real handshakes.

## Interface
- SB_LOG2, 6: log2 of superblock edge in pixels (6 gives 64).
- DIM_W, 16: width of frame dimension inputs.
- BURST, 16: maximum pixels per output write beat (1..255).
- TO_W, 10: watchdog counter width.
- TIMEOUT, 1023: maximum cycles a stage may wait for done (must be less than 2^TO_W).
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  start tile; sampled only in IDLE.
- abort  in  1  synchronous abort; highest priority after rst.
- frame_width, frame_height  in  DIM_W  frame size in pixels; latched on start.
- stage_req  out  3  one-hot stage request: bit0 entropy, bit1 itx, bit2 pred.
- stage_done  in  3  stage completion, matched to stage_req bit.
- wr_valid  out  1  write beat valid.
- wr_ready  in  1  write beat accepted.
- wr_addr  out  2*DIM_W  pixel offset of beat.
- wr_len  out  8  pixels in beat.
- sb_row, sb_col  out  DIM_W  current superblock coordinate.
- sb_count  out  2*DIM_W  superblocks completed this tile.
- state  out  4  current state code.
- busy  out  1  state is not IDLE and not ERROR.
- tile_done  out  1  one-cycle completion pulse.
- error  out  1  sticky watchdog error.
- err_stage  out  2  stage that timed out: 0 entropy, 1 itx, 2 pred.

## Operation
- State codes: IDLE=0, SB_HDR=1, ENT=2, ITX=3, PRED=4, RECON=5, WRITE=6, DONE=7, NEXT_SB=8, ERROR=9.
- Reset: all outputs are 0 and the state is IDLE. This applies on the cycle after rst is sampled high, including mid-operation.
- In IDLE, start latches the dimensions and computes the following. The state then goes to SB_HDR, or straight to DONE if width or height is 0.
  - sb_cols = (W + 2^SB_LOG2 − 1) >> SB_LOG2, computed in DIM_W+1 bits so there is no overflow at W = 2^DIM_W − 1. sb_rows is computed the same way from H.
  - total = W*H, 2*DIM_W bits.
  - sb_row, sb_col, sb_count and the write offset are all cleared to 0.
- SB_HDR goes to ENT after 1 cycle.
- ENT, ITX and PRED each hold their stage_req bit high for the whole time the state is active.
  - The stage completes on the first cycle its stage_done bit is high. The next state is entered on the following cycle.
  - stage_done bits that do not match the active request are ignored.
  - Stage order is ENT → ITX → PRED → RECON.
- Watchdog:
  - The counter clears on entry to each stage and increments every cycle without done.
  - If the counter equals TIMEOUT and done is low, the next state is ERROR, with error=1 and err_stage set to that stage.
  - If done and counter==TIMEOUT occur on the same cycle, done wins.
- RECON goes to NEXT_SB after 1 cycle.
- NEXT_SB increments sb_count, then:
  - if sb_col < sb_cols−1: sb_col+1, go to SB_HDR;
  - else if sb_row < sb_rows−1: sb_col=0, sb_row+1, go to SB_HDR;
  - else go to WRITE.
- WRITE:
  - wr_valid=1, wr_addr=offset, wr_len=min(BURST, total−offset).
  - On wr_valid&wr_ready, offset += wr_len. If offset+wr_len == total, go to DONE.
  - While wr_ready=0, wr_addr and wr_len must stay stable.
- DONE: tile_done=1 for exactly this cycle, then go to IDLE.
- ERROR: stage_req=0, wr_valid=0, start ignored. The block leaves ERROR only via abort or rst, both of which clear error and err_stage.
- abort in any state:
  - next state is IDLE;
  - stage_req=0, wr_valid=0, no tile_done;
  - sb_count is held, and cleared on the next start.
- start outside IDLE is ignored. Dimension changes after start have no effect.

## Timing
- All outputs are registered. stage_req and wr_valid are asserted in the first cycle of their state.
- Minimum time per superblock is 6 cycles (HDR, ENT, ITX, PRED, RECON, NEXT_SB), with done high on the first request cycle.
- start at cycle t gives SB_HDR at t+1. With every stage done immediately, WRITE is entered at t+6N+1, where N is the number of superblocks.
- One write beat completes per cycle when wr_ready=1.
- A zero-size frame: start at t gives DONE/tile_done at t+1 and IDLE at t+2.

## Test plan
- 64×64, stage_done=3'b111, wr_ready=1, start at t0:
  - ENT at t2, WRITE at t7–t262 (256 beats, wr_len=16);
  - tile_done at t263 only, sb_count=1, IDLE at t264.
- 130×70, SB_LOG2=6: sb visit order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), sb_count=6, total 9100, 569 beats, last beat wr_addr=9088, wr_len=12.
- TIMEOUT=15, itx done held low: entering ITX at cycle e gives ERROR at e+16 with error=1, err_stage=1, stage_req=0. start is ignored. abort then gives IDLE with error=0.
- Done on the cycle the counter reaches TIMEOUT: the stage advances and no error is raised. Stray stage_done[2] during ENT has no effect.
- wr_ready toggled 1,0,0,1: wr_addr is stable across the stalls and the offset advances only on accepted beats. abort mid-WRITE gives IDLE next cycle with wr_valid=0 and no tile_done.
- rst high during ENT: next cycle all outputs are 0 and the state is IDLE. frame_width=0 start gives tile_done at t+1 with stage_req never asserted.
